// File: rtl/quadrature_acc_window_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : quadrature_acc_window_reader
// Description : Samples the free-running SIN/COS mul-acc accumulators on ADC
//               zero-cross strobes and emits per-window sums (acc_now minus
//               acc_at_window_start) through a 2-entry valid/ready FIFO.
//               Optional macro QUAD_READER_PERIOD_COUNT_EN adds OUT_CLOCKS,
//               the number of CE cycles spanned by each window.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrature_acc_window_reader #(
    parameter int RESULT_WIDTH   = 32,
    parameter int PERIOD_BITS    = 4,
    parameter int OVF_BITS       = 8,
    parameter int CLK_COUNT_BITS = 24
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      CE,
    input  logic [RESULT_WIDTH-1:0]   SIN_ACC,
    input  logic [RESULT_WIDTH-1:0]   COS_ACC,
    input  logic                      ZERO_CROSS,
    input  logic [PERIOD_BITS-1:0]    PERIODS,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [RESULT_WIDTH-1:0]   OUT_SIN,
    output logic [RESULT_WIDTH-1:0]   OUT_COS,
`ifdef QUAD_READER_PERIOD_COUNT_EN
    output logic [CLK_COUNT_BITS-1:0] OUT_CLOCKS,
`endif
    output logic [OVF_BITS-1:0]       OVERFLOW
);

    // Reject degenerate parameterisations at elaboration time.
    if (RESULT_WIDTH < 1 || PERIOD_BITS < 1 || OVF_BITS < 1 || CLK_COUNT_BITS < 1) begin : g_param_check
        $error("quadrature_acc_window_reader: all widths must be at least 1");
    end

    // FIFO entry layout, LSB first: sin diff, cos diff, [window clock count].
`ifdef QUAD_READER_PERIOD_COUNT_EN
    localparam int ENTRY_W = 2 * RESULT_WIDTH + CLK_COUNT_BITS;
`else
    localparam int ENTRY_W = 2 * RESULT_WIDTH;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state_q,  state_d;
    logic [RESULT_WIDTH-1:0]   base_s_q, base_s_d;
    logic [RESULT_WIDTH-1:0]   base_c_q, base_c_d;
    logic [PERIOD_BITS-1:0]    xcount_q, xcount_d;
    logic [PERIOD_BITS-1:0]    plen_q,   plen_d;
    logic [ENTRY_W-1:0]        diff_q,   diff_d;
    logic                      diff_vld_q, diff_vld_d;
    logic [ENTRY_W-1:0]        head_q,   head_d;
    logic [ENTRY_W-1:0]        tail_q,   tail_d;
    logic [1:0]                count_q,  count_d;
    logic [OVF_BITS-1:0]       ovf_q,    ovf_d;

    logic                      strobe;
    logic                      window_end;
    logic [PERIOD_BITS-1:0]    plen_new;
    logic [RESULT_WIDTH-1:0]   sin_diff;
    logic [RESULT_WIDTH-1:0]   cos_diff;
    logic [ENTRY_W-1:0]        new_entry;
    logic                      pop;
    logic                      push_ok;
    logic                      drop;

    assign strobe     = ZERO_CROSS & CE;
    // A programmed window length of zero is meaningless; run it as one crossing.
    assign plen_new   = (PERIODS == '0) ? PERIOD_BITS'(1) : PERIODS;
    assign window_end = (state_q == ST_RUN) &&
                        (({1'b0, xcount_q} + (PERIOD_BITS + 1)'(1)) == {1'b0, plen_q});
    // Modulo subtraction: accumulator wrap between the two samples cancels out.
    assign sin_diff   = SIN_ACC - base_s_q;
    assign cos_diff   = COS_ACC - base_c_q;

`ifdef QUAD_READER_PERIOD_COUNT_EN
    logic [CLK_COUNT_BITS-1:0] clk_cnt_q, clk_cnt_d;
    logic [CLK_COUNT_BITS-1:0] clk_inc;

    // Saturating count of CE cycles; the end strobe itself is included via clk_inc.
    assign clk_inc   = (clk_cnt_q == '1) ? clk_cnt_q : clk_cnt_q + CLK_COUNT_BITS'(1);
    assign new_entry = {clk_inc, cos_diff, sin_diff};

    // Window clock counter: restarts on every window-start strobe.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        if (strobe && (state_q == ST_IDLE || window_end)) begin
            clk_cnt_d = '0;
        end else if (CE) begin
            clk_cnt_d = clk_inc;
        end
    end

    // Window clock counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

    assign OUT_CLOCKS = head_q[ENTRY_W-1 -: CLK_COUNT_BITS];
`else
    assign new_entry = {cos_diff, sin_diff};
`endif

    // Capture side: window FSM, base snapshot and crossing counter; CE-gated via strobe.
    always_comb begin
        state_d    = state_q;
        base_s_d   = base_s_q;
        base_c_d   = base_c_q;
        xcount_d   = xcount_q;
        plen_d     = plen_q;
        diff_d     = diff_q;
        diff_vld_d = 1'b0;
        if (strobe) begin
            if (state_q == ST_IDLE || window_end) begin
                // Every window boundary rebases and latches the next length.
                base_s_d = SIN_ACC;
                base_c_d = COS_ACC;
                xcount_d = '0;
                plen_d   = plen_new;
                state_d  = ST_RUN;
                if (window_end) begin
                    diff_d     = new_entry;
                    diff_vld_d = 1'b1;
                end
            end else begin
                xcount_d = xcount_q + PERIOD_BITS'(1);
            end
        end
    end

    // Capture-side registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            base_s_q   <= '0;
            base_c_q   <= '0;
            xcount_q   <= '0;
            plen_q     <= PERIOD_BITS'(1);
            diff_q     <= '0;
            diff_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_s_q   <= base_s_d;
            base_c_q   <= base_c_d;
            xcount_q   <= xcount_d;
            plen_q     <= plen_d;
            diff_q     <= diff_d;
            diff_vld_q <= diff_vld_d;
        end
    end

    // A pop frees a slot in the same cycle, so a write into a full FIFO with a
    // concurrent pop is accepted rather than dropped.
    assign pop     = (count_q != 2'd0) && OUT_READY;
    assign push_ok = diff_vld_q && ((count_q != 2'd2) || pop);
    assign drop    = diff_vld_q && !push_ok;

    // Two-entry FIFO next state; head is held in place so outputs stay registered.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (count_q)
            2'd0: begin
                if (push_ok) begin
                    head_d  = diff_q;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_ok && pop) begin
                    head_d = diff_q;
                end else if (push_ok) begin
                    tail_d  = diff_q;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_ok) begin
                        tail_d = diff_q;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
        if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_BITS'(1);
        end
    end

    // FIFO and overflow registers; these run regardless of CE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ovf_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT_VALID = (count_q != 2'd0);
    assign OUT_SIN   = head_q[RESULT_WIDTH-1:0];
    assign OUT_COS   = head_q[2*RESULT_WIDTH-1:RESULT_WIDTH];
    assign OVERFLOW  = ovf_q;

endmodule
`default_nettype wire
